dadda_mult_pipe: RTL

Parametrised, pipelined Dadda-tree multiplier. It replaces the fixed 4x4 combinational multiplier wherever a registered, back-pressurable multiply of configurable width is needed. Operands are accepted through a valid/ready handshake and pass through three register stages: operand capture, Dadda reduction to two rows, and final carry-propagate add. One product is accepted per cycle when not stalled.

---
 rtl/dadda_mult_pipe_if.sv | 54 +++++
 rtl/dadda_mult_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mult_pipe_if.sv
// ---------------------------------------------------------------------------
// dadda_mult_pipe_if
//
// Handshake bundle for the pipelined Dadda multiplier.
//
// Signals:
//   in_valid    producer -> multiplier  operand pair on x/y is presented
//   in_ready    multiplier -> producer  multiplier can accept this cycle
//   x, y        producer -> multiplier  operands, WIDTH bits each
//   signed_mode producer -> multiplier  two's-complement operands
//               (exists only when DADDA_SIGNED_EN is defined)
//   out_valid   multiplier -> consumer  out holds a completed product
//   out_ready   consumer -> multiplier  consumer takes out this cycle
//   out         multiplier -> consumer  product, 2*WIDTH bits
//   occupancy   multiplier -> observer  valid stages in flight (0..3)
//
// Modports: master = the side driving operands and consuming products,
//           slave  = the multiplier itself.
// ---------------------------------------------------------------------------
interface dadda_mult_pipe_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
`ifdef DADDA_SIGNED_EN
    logic                 signed_mode;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;
    logic [1:0]           occupancy;

`ifdef DADDA_SIGNED_EN
    modport master (
        output in_valid, x, y, signed_mode, out_ready,
        input  in_ready, out_valid, out, occupancy
    );
    modport slave (
        input  in_valid, x, y, signed_mode, out_ready,
        output in_ready, out_valid, out, occupancy
    );
`else
    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, out, occupancy
    );
    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, out, occupancy
    );
`endif
endinterface

// File: rtl/dadda_mult_pipe.sv
// ---------------------------------------------------------------------------
// dadda_mult_pipe
//
// Pipelined, back-pressurable WIDTH x WIDTH multiplier built on a Dadda
// reduction tree. Three register stages:
//   S1  operand capture
//   S2  partial products reduced to two 2*WIDTH rows
//   S3  carry-propagate add of the two rows
// One product per cycle is accepted while the output is not stalled. The
// whole pipeline advances together on adv = !out_valid | out_ready; bubbles
// are not collapsed.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high; clears the valid bits and the product
//   bus  dadda_mult_pipe_if.slave (in_valid/in_ready/x/y[/signed_mode],
//        out_valid/out_ready/out, occupancy)
//
// Parameter:
//   WIDTH  operand width, 2..16; product is 2*WIDTH bits
//
// Build option:
//   DADDA_SIGNED_EN  when defined, adds signed_mode; with signed_mode=1 the
//                    tree uses Baugh-Wooley partial products and yields the
//                    two's-complement product. Undefined: unsigned only.
// ---------------------------------------------------------------------------
module dadda_mult_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    dadda_mult_pipe_if.slave bus
);
    localparam int PW   = 2 * WIDTH;
    // Working column size: tallest column plus carries arriving from the
    // column below within one reduction stage.
    localparam int HMAX = 2 * WIDTH + 2;
    localparam int NSTG = 6;

    logic            adv;
    logic            vld_p0;
    logic            vld_p1;
    logic            vld_p2;
    logic [WIDTH-1:0] x_p0;
    logic [WIDTH-1:0] y_p0;
`ifdef DADDA_SIGNED_EN
    logic            sm_p0;
`endif
    logic [PW-1:0]   row_a;
    logic [PW-1:0]   row_b;
    logic [PW-1:0]   row_a_p1;
    logic [PW-1:0]   row_b_p1;
    logic [PW-1:0]   prod_p2;

    // Dadda target heights, largest first. Stages whose target is not below
    // the current tallest column reduce nothing and collapse to wires.
    function automatic int dadda_height(input int s);
        case (s)
            0:       return 13;
            1:       return 9;
            2:       return 6;
            3:       return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    // Builds the partial-product columns and reduces every column to at most
    // two bits with full/half adders. Returns {row_b, row_a}. All counts are
    // derived from WIDTH only, so the loop structure folds into a fixed tree.
    function automatic logic [2*PW-1:0] dadda_rows(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
`ifdef DADDA_SIGNED_EN
        ,
        input logic             sm
`endif
    );
        logic [HMAX-1:0] cur  [PW];
        int              ccnt [PW];
        logic [HMAX-1:0] w;
        logic [HMAX-1:0] pend;
        logic [HMAX-1:0] npend;
        logic [PW-1:0]   ra;
        logic [PW-1:0]   rb;
        logic            pp;
        int              pc;
        int              npc;
        int              wc;
        int              p;
        int              o;
        int              d;
        int              h;

        ra = '0;
        rb = '0;
        w = '0;
        pend = '0;
        npend = '0;
        pc = 0;
        npc = 0;
        wc = 0;
        p = 0;
        o = 0;
        d = 0;
        h = 0;
        pp = 1'b0;
        for (int i = 0; i < PW; i++) begin
            cur[i]  = '0;
            ccnt[i] = 0;
        end

        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp = a[i] & b[j];
`ifdef DADDA_SIGNED_EN
                // Baugh-Wooley: terms in the MSB row or MSB column (but not
                // both) carry negative weight and are complemented.
                if (sm && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                    pp = ~pp;
`endif
                cur[i+j][ccnt[i+j]] = pp;
                ccnt[i+j] = ccnt[i+j] + 1;
            end
        end

`ifdef DADDA_SIGNED_EN
        // Correction constants for the complemented terms. They occupy fixed
        // slots carrying sm, so the tree shape does not depend on the mode.
        cur[WIDTH][ccnt[WIDTH]] = sm;
        ccnt[WIDTH] = ccnt[WIDTH] + 1;
        cur[PW-1][ccnt[PW-1]] = sm;
        ccnt[PW-1] = ccnt[PW-1] + 1;
`endif

        for (int s = 0; s < NSTG; s++) begin
            d = dadda_height(s);
            pend = '0;
            pc = 0;
            for (int i = 0; i < PW; i++) begin
                // Column work list: the column's own bits, then the carries
                // produced by the column below in this stage.
                w  = cur[i];
                wc = ccnt[i];
                for (int k = 0; k < HMAX; k++) begin
                    if (k < pc) begin
                        w[wc] = pend[k];
                        wc = wc + 1;
                    end
                end
                npend = '0;
                npc = 0;
                p = 0;
                o = 0;
                cur[i] = '0;
                for (int k = 0; k < HMAX; k++) begin
                    h = (wc - p) + o;
                    if ((h > d) && ((wc - p) >= 2)) begin
                        if (((h - d) >= 2) && ((wc - p) >= 3)) begin
                            cur[i][o]   = w[p] ^ w[p+1] ^ w[p+2];
                            npend[npc] = (w[p] & w[p+1]) | (w[p+2] & (w[p] ^ w[p+1]));
                            p = p + 3;
                        end else begin
                            cur[i][o]   = w[p] ^ w[p+1];
                            npend[npc] = w[p] & w[p+1];
                            p = p + 2;
                        end
                        o = o + 1;
                        npc = npc + 1;
                    end
                end
                for (int k = 0; k < HMAX; k++) begin
                    if (p < wc) begin
                        cur[i][o] = w[p];
                        o = o + 1;
                        p = p + 1;
                    end
                end
                ccnt[i] = o;
                // Carries out of the top column fall off: product is mod 2^PW.
                pend = npend;
                pc = npc;
            end
        end

        for (int i = 0; i < PW; i++) begin
            ra[i] = cur[i][0];
            rb[i] = cur[i][1];
        end
        return {rb, ra};
    endfunction

    assign adv           = !vld_p2 || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_p2;
    assign bus.out       = prod_p2;
    assign bus.occupancy = 2'(vld_p0) + 2'(vld_p1) + 2'(vld_p2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ---- S1: operand capture ----
    always_ff @(posedge clk) begin
        if (adv) begin
            x_p0 <= bus.x;
            y_p0 <= bus.y;
`ifdef DADDA_SIGNED_EN
            sm_p0 <= bus.signed_mode;
`endif
        end
    end

    // ---- S2: Dadda reduction to two rows ----
    always_comb begin
`ifdef DADDA_SIGNED_EN
        {row_b, row_a} = dadda_rows(x_p0, y_p0, sm_p0);
`else
        {row_b, row_a} = dadda_rows(x_p0, y_p0);
`endif
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            row_a_p1 <= row_a;
            row_b_p1 <= row_b;
        end
    end

    // ---- S3: final carry-propagate add ----
    // Reset to zero so the output is deterministic straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_p2 <= '0;
        end else if (adv) begin
            prod_p2 <= row_a_p1 + row_b_p1;
        end
    end
endmodule
